// File: rtl/fig_6_alu_result_stage_if.sv
// fig_6_alu_result_stage_if: adder-result, writeback and flag signals of the ALU result stage.
interface fig_6_alu_result_stage_if #(
   parameter int WIDTH = 16
);
   logic             alu_valid;
   logic             alu_ready;
   logic [WIDTH-1:0] alu_z;
   logic             alu_cy;
   logic             alu_ov;
   logic [3:0]       alu_dest;
   logic             alu_flag_we;
   logic             alu_wb_en;
   logic             carry_src;
   logic             wb_valid;
   logic             wb_ready;
   logic [WIDTH-1:0] wb_data;
   logic [3:0]       wb_dest;
   logic             sfr_we;
   logic [3:0]       sfr_wdata;
   logic             flag_z;
   logic             flag_cy;
   logic             flag_s;
   logic             flag_ov;

   modport master (
      output alu_valid, alu_z, alu_cy, alu_ov, alu_dest, alu_flag_we, alu_wb_en,
             wb_ready, sfr_we, sfr_wdata,
      input  alu_ready, carry_src, wb_valid, wb_data, wb_dest,
             flag_z, flag_cy, flag_s, flag_ov
   );

   modport slave (
      input  alu_valid, alu_z, alu_cy, alu_ov, alu_dest, alu_flag_we, alu_wb_en,
             wb_ready, sfr_we, sfr_wdata,
      output alu_ready, carry_src, wb_valid, wb_data, wb_dest,
             flag_z, flag_cy, flag_s, flag_ov
   );
endinterface

// File: rtl/fig_6_alu_result_stage.sv
// fig_6_alu_result_stage: buffers adder results in a 2-entry writeback queue
// and maintains the Z/CY/S/OV status flags.
module fig_6_alu_result_stage #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input logic                     clk,
   input logic                     rst,
   fig_6_alu_result_stage_if.slave bus
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   state_t           state_q, state_d;
   logic [WIDTH+3:0] head_q, head_d, tail_q, tail_d;
   logic [3:0]       flags_q, flags_d;
   logic             accept, push, pop;
   logic [WIDTH+3:0] entry;
   // State encoding equals occupancy, so ready is a pure function of registered state.
   assign bus.alu_ready = 32'(state_q) < DEPTH;
   assign bus.wb_valid  = state_q != EMPTY;
   assign bus.wb_data   = head_q[WIDTH+3:4];
   assign bus.wb_dest   = head_q[3:0];
   assign bus.carry_src = flags_q[1];
   assign {bus.flag_ov, bus.flag_s, bus.flag_cy, bus.flag_z} = flags_q;
   assign accept = bus.alu_valid & bus.alu_ready;
   assign push   = accept & bus.alu_wb_en;
   assign pop    = bus.wb_valid & bus.wb_ready;
   assign entry  = {bus.alu_z, bus.alu_dest};
   assign flags_d = bus.sfr_we ? bus.sfr_wdata
                  : (accept & bus.alu_flag_we) ? {bus.alu_ov, bus.alu_z[WIDTH-1], bus.alu_cy, bus.alu_z == '0}
                  : flags_q;
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: if (push) begin
            state_d = ONE;
            head_d  = entry;
         end
         ONE: if (push && pop) begin
            head_d = entry;
         end else if (push) begin
            state_d = TWO;
            tail_d  = entry;
         end else if (pop) begin
            state_d = EMPTY;
         end
         TWO: if (pop) begin
            state_d = ONE;
            head_d  = tail_q;
         end
         default: state_d = EMPTY;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         flags_q <= flags_d;
      end
   end
endmodule

// File: tb/tb_fig_6_alu_result_stage.sv
// tb_fig_6_alu_result_stage: directed literal checks plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_fig_6_alu_result_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;
   fig_6_alu_result_stage_if #(.WIDTH(16)) bus();
   fig_6_alu_result_stage #(.WIDTH(16), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   logic [19:0] m_q[$];
   logic [3:0]  m_flags = 4'd0;
   bit          started = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of {data, dest} and a 4-bit flag word.
   always @(posedge clk) begin
      if (rst) begin
         m_q.delete();
         m_flags = 4'd0;
         started = 1'b1;
      end else if (started) begin
         automatic bit acc = bus.alu_valid && m_q.size() < 2;
         if (m_q.size() > 0 && bus.wb_ready) void'(m_q.pop_front());
         if (acc && bus.alu_wb_en) m_q.push_back({bus.alu_z, bus.alu_dest});
         if (bus.sfr_we) m_flags = bus.sfr_wdata;
         else if (acc && bus.alu_flag_we)
            m_flags = {bus.alu_ov, bus.alu_z[15], bus.alu_cy, bus.alu_z == 16'd0};
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("m_ready", bus.alu_ready, m_q.size() < 2);
         chk("m_wb_valid", bus.wb_valid, m_q.size() != 0);
         if (m_q.size() != 0) begin
            chk("m_wb_data", bus.wb_data, m_q[0][19:4]);
            chk("m_wb_dest", bus.wb_dest, m_q[0][3:0]);
         end
         chk("m_flags", {bus.flag_ov, bus.flag_s, bus.flag_cy, bus.flag_z}, m_flags);
         chk("m_carry_src", bus.carry_src, m_flags[1]);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic op(input logic [15:0] z, input logic cy, input logic ov, input logic [3:0] d,
                     input logic fwe, input logic wen);
      bus.alu_valid = 1'b1;
      bus.alu_z = z;
      bus.alu_cy = cy;
      bus.alu_ov = ov;
      bus.alu_dest = d;
      bus.alu_flag_we = fwe;
      bus.alu_wb_en = wen;
   endtask

   function automatic logic [3:0] flags();
      return {bus.flag_ov, bus.flag_s, bus.flag_cy, bus.flag_z};
   endfunction

   initial begin
      bus.alu_valid = 1'b0; bus.alu_z = '0; bus.alu_cy = 1'b0; bus.alu_ov = 1'b0;
      bus.alu_dest = '0; bus.alu_flag_we = 1'b0; bus.alu_wb_en = 1'b0;
      bus.wb_ready = 1'b0; bus.sfr_we = 1'b0; bus.sfr_wdata = '0;
      repeat (2) tick();
      rst = 1'b0;
      chk("rst_wb_valid", bus.wb_valid, 0);
      chk("rst_wb_data", bus.wb_data, 0);
      chk("rst_wb_dest", bus.wb_dest, 0);
      chk("rst_flags", flags(), 0);
      chk("rst_carry_src", bus.carry_src, 0);
      chk("rst_ready", bus.alu_ready, 1);
      // ADD producing zero with carry
      bus.wb_ready = 1'b1;
      op(16'h0000, 1, 0, 4'd3, 1, 1); tick();
      chk("add_flags", flags(), 4'b0011);
      chk("add_wb_valid", bus.wb_valid, 1);
      chk("add_wb_data", bus.wb_data, 16'h0000);
      chk("add_wb_dest", bus.wb_dest, 3);
      chk("add_carry_src", bus.carry_src, 1);
      bus.alu_valid = 1'b0; tick();
      chk("add_drained", bus.wb_valid, 0);
      // signed overflow
      op(16'h8000, 0, 1, 4'd5, 1, 1); tick();
      chk("ov_flags", flags(), 4'b1100);
      bus.alu_valid = 1'b0; tick();
      chk("ov_carry_src", bus.carry_src, 0);
      // CMP: flags only
      op(16'h1234, 1, 0, 4'd2, 1, 0); tick();
      chk("cmp_flags", flags(), 4'b0010);
      chk("cmp_no_wb", bus.wb_valid, 0);
      // backpressure
      bus.wb_ready = 1'b0;
      op(16'h1111, 0, 0, 4'd1, 1, 1); tick();
      op(16'h2222, 0, 0, 4'd2, 1, 1); tick();
      chk("bp_ready_low", bus.alu_ready, 0);
      chk("bp_head", bus.wb_data, 16'h1111);
      op(16'h3333, 1, 0, 4'd3, 1, 1); tick();
      chk("bp_still_low", bus.alu_ready, 0);
      chk("bp_flags", flags(), 4'b0000);
      chk("bp_head_hold", bus.wb_data, 16'h1111);
      chk("bp_dest_hold", bus.wb_dest, 1);
      bus.wb_ready = 1'b1; tick();
      chk("bp_second_head", bus.wb_data, 16'h2222);
      chk("bp_second_dest", bus.wb_dest, 2);
      chk("bp_ready_back", bus.alu_ready, 1);
      chk("bp_flags_kept", flags(), 4'b0000);
      tick();
      chk("bp_third_head", bus.wb_data, 16'h3333);
      chk("bp_third_dest", bus.wb_dest, 3);
      chk("bp_third_flags", flags(), 4'b0010);
      bus.alu_valid = 1'b0; tick();
      chk("bp_drained", bus.wb_valid, 0);
      // SFR write beats the op's flag update
      bus.wb_ready = 1'b0;
      bus.sfr_we = 1'b1; bus.sfr_wdata = 4'b0010;
      op(16'h0000, 0, 1, 4'd7, 1, 1); tick();
      chk("sfr_flags", flags(), 4'b0010);
      chk("sfr_wb_valid", bus.wb_valid, 1);
      chk("sfr_wb_data", bus.wb_data, 16'h0000);
      chk("sfr_wb_dest", bus.wb_dest, 7);
      bus.sfr_we = 1'b0; bus.alu_valid = 1'b0; bus.wb_ready = 1'b1; tick();
      chk("sfr_drained", bus.wb_valid, 0);
      // reset with two entries held
      bus.wb_ready = 1'b0;
      op(16'hFFFF, 1, 1, 4'd9, 1, 1); tick();
      op(16'h0000, 1, 1, 4'd10, 1, 1); tick();
      chk("mid_full", bus.alu_ready, 0);
      chk("mid_flags", flags(), 4'b1011);
      rst = 1'b1; bus.sfr_we = 1'b1; bus.sfr_wdata = 4'hF; bus.wb_ready = 1'b1; tick();
      chk("mid_rst_wb_valid", bus.wb_valid, 0);
      chk("mid_rst_flags", flags(), 0);
      chk("mid_rst_ready", bus.alu_ready, 1);
      rst = 1'b0; bus.sfr_we = 1'b0; bus.alu_valid = 1'b0;
      repeat (3) begin
         tick();
         chk("mid_rst_no_stale", bus.wb_valid, 0);
      end
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         automatic int sel = $urandom_range(0, 9);
         bus.alu_valid = $urandom_range(0, 9) < 7;
         bus.alu_z = sel == 0 ? 16'h0000 : sel == 1 ? 16'h8000 : 16'($urandom);
         bus.alu_cy = 1'($urandom);
         bus.alu_ov = 1'($urandom);
         bus.alu_dest = 4'($urandom);
         bus.alu_flag_we = $urandom_range(0, 9) < 8;
         bus.alu_wb_en = $urandom_range(0, 3) != 0;
         bus.wb_ready = $urandom_range(0, 9) < 6;
         bus.sfr_we = $urandom_range(0, 9) == 0;
         bus.sfr_wdata = 4'($urandom);
         rst = $urandom_range(0, 199) == 0;
         tick();
      end
      rst = 1'b0;
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/fig_6_alu_result_stage.md
Name: fig_6_alu_result_stage

Overview:
- Registered stage directly downstream of the ALU adder/subtractor (block 152 of Figure 6).
- Captures each adder result (z, cy, ov) into a 2-entry writeback buffer headed for the register file.
- Derives the zero and sign flags and maintains the architectural status flags Z, CY, S, OV.
- Feeds the current CY back to the adder as the carry source for ADC/SBC.

Parameters:
- WIDTH, 16, data path width; sign flag taken from bit WIDTH-1.
- DEPTH, 2, writeback buffer entries; fixed at 2 (not a general FIFO).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  adder result presented this cycle.
- alu_ready  out  1  stage can accept a result; high when the buffer holds fewer than 2 entries.
- alu_z  in  WIDTH  adder sum/difference.
- alu_cy  in  1  adder carry (unsigned; already inverted for subtract).
- alu_ov  in  1  adder signed overflow.
- alu_dest  in  4  destination register index R0-R15.
- alu_flag_we  in  1  the operation updates flags (ADD/ADC/SUB/SBC = 1; CMP = 1 with alu_wb_en = 0).
- alu_wb_en  in  1  the operation writes the register file.
- carry_src  out  1  current CY flag, consumed by the adder for ADC/SBC.
- wb_valid  out  1  buffer head holds a pending write.
- wb_ready  in  1  register file accepts the write this cycle.
- wb_data  out  WIDTH  head data.
- wb_dest  out  4  head destination index.
- sfr_we  in  1  host/SFR write of the flags.
- sfr_wdata  in  4  {ov, s, cy, z}.
- flag_z, flag_cy, flag_s, flag_ov  out  1 each  architectural flags.

Behaviour:
- Reset: buffer empty, wb_valid=0, wb_data=0, wb_dest=0, all flags 0, carry_src=0, alu_ready=1.
- Accept: on a clk edge with alu_valid & alu_ready.
- Flag update on accept with alu_flag_we=1, effective the next cycle (1-cycle latency):
  - Z = (alu_z == 0)
  - S = alu_z[WIDTH-1]
  - CY = alu_cy
  - OV = alu_ov
- carry_src = flag_cy (registered, no bypass). An ADC accepted the cycle after an ADD sees that ADD's carry.
- sfr_we wins over a simultaneous flag update from an accepted op. The op's result is still buffered.
- Buffer entry: an accept with alu_wb_en=1 pushes {alu_z, alu_dest}. With alu_wb_en=0 nothing is pushed and only flags change.
- Buffer states:
  - EMPTY: push goes to ONE.
  - ONE: push without pop goes to TWO. Push with pop stays in ONE, and the head takes the new data on the next edge. Pop without push goes to EMPTY.
  - TWO: alu_ready=0, so no push. Pop goes to ONE, and the second entry becomes the head.
- Pop occurs when wb_valid & wb_ready.
- Zero-latency pass-through is forbidden. A result reaches wb_* no earlier than the cycle after accept.
- Buffer order is strict FIFO. Entries are never dropped or duplicated.
- alu_ready depends only on the registered occupancy, with no combinational path from wb_ready. Consequence: in TWO a same-cycle pop does not enable a push.
- alu_valid while alu_ready=0: ignored. Flags are unchanged and the upstream holds its data.
- wb_data and wb_dest hold stable while wb_valid=1 and wb_ready=0.
- Reset asserted mid-operation: on that edge the buffer flushes and flags clear, regardless of valid/ready/sfr_we.

Test Plan:
- Reset then ADD: alu_z=0x0000, cy=1, ov=0, dest=3, flag_we=1, wb_en=1, wb_ready=1 -> next cycle Z=1, CY=1, S=0, OV=0, wb_valid=1, wb_data=0x0000, wb_dest=3. The following cycle wb_valid=0.
- Overflow result: alu_z=0x8000, cy=0, ov=1 -> Z=0, S=1, CY=0, OV=1. carry_src=0 in the following cycle.
- CMP-style op: alu_z=0x1234, wb_en=0, flag_we=1 -> flags update (Z=0, S=0), wb_valid stays 0.
- Backpressure: wb_ready=0; push 0x1111 (R1), then 0x2222 (R2), then 0x3333 presented:
  - alu_ready=0 after the second push; the third is not accepted and flags reflect 0x2222.
  - Raise wb_ready: writes pop in order 0x1111, then 0x2222.
  - alu_ready returns to 1 the cycle after the first pop; 0x3333 is then accepted and popped third.
- Simultaneous events: sfr_we=1, sfr_wdata=4'b0010 in the same cycle as an accepted op with flag_we=1, alu_z=0 -> flags Z=0, CY=1, S=0, OV=0 and the result is still buffered.
- Reset mid-stream: with TWO entries held and flags set, assert rst for one cycle -> wb_valid=0, all flags 0, alu_ready=1, and no stale write issued afterwards.
